// File: rtl/lamp_pkg.sv
// Shared encodings for the lamp pattern decoder: mode codes, FSM states, default confirm depth.
package lamp_pkg;

  localparam logic [1:0] MODE_UNKNOWN   = 2'd0;
  localparam logic [1:0] MODE_STEADY_ON = 2'd1;
  localparam logic [1:0] MODE_OFF       = 2'd2;
  localparam logic [1:0] MODE_BLINK     = 2'd3;

  localparam int CONFIRM_N_DEF = 2;

  typedef enum logic [2:0] {
    ST_UNKNOWN,
    ST_STEADY_ON,
    ST_OFF,
    ST_BLINK_A,
    ST_BLINK_B
  } lamp_dec_state_t;

  function automatic logic [1:0] state_mode(input lamp_dec_state_t st);
    case (st)
      ST_STEADY_ON:           state_mode = MODE_STEADY_ON;
      ST_OFF:                 state_mode = MODE_OFF;
      ST_BLINK_A, ST_BLINK_B: state_mode = MODE_BLINK;
      default:                state_mode = MODE_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/lamp_pattern_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together load one.
module sat_counter #(
  parameter int W = 4,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] base;
  logic [W-1:0] cnt_nxt;

  always_comb begin
    base    = clr ? '0 : cnt;
    cnt_nxt = base;
    if (inc && (base != LIMIT)) cnt_nxt = base + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/lamp_pattern_decoder.sv
// Decodes sampled lamp pair back to controller commands (i, s), checks blink alternation, counts blink periods.
// Optional LAMP_DEC_STICKY_ERR_EN: err holds until clr/Reset instead of pulsing for one cycle.
module lamp_pattern_decoder
  import lamp_pkg::*;
#(
  parameter int CONFIRM_N = CONFIRM_N_DEF,
  parameter int CNT_W     = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             sample,
  input  logic             l1,
  input  logic             l2,
  input  logic             clr,
  output logic             i_rec,
  output logic             s_rec,
  output logic [1:0]       mode,
  output logic             valid,
  output logic             err,
  output logic [CNT_W-1:0] blink_cnt
);

  lamp_dec_state_t state, state_nxt;
  logic            fault;
  logic            same_class;
  logic            blink_inc;
  logic [3:0]      conf_cnt;
  logic            i_hold, s_hold;
  logic            i_now, s_now;

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_UNKNOWN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fault      = 1'b0;
    same_class = 1'b0;
    blink_inc  = 1'b0;
    if (sample) begin
      case ({l1, l2})
        2'b11: begin
          state_nxt  = ST_STEADY_ON;
          same_class = (state == ST_STEADY_ON);
        end
        2'b00: begin
          state_nxt  = ST_OFF;
          same_class = (state == ST_OFF);
        end
        2'b10: begin
          case (state)
            ST_BLINK_A: fault = 1'b1;
            ST_BLINK_B: begin
              state_nxt  = ST_BLINK_A;
              same_class = 1'b1;
              blink_inc  = 1'b1;
            end
            default:    state_nxt = ST_BLINK_A;
          endcase
        end
        default: begin
          case (state)
            ST_BLINK_B: fault = 1'b1;
            ST_BLINK_A: begin
              state_nxt  = ST_BLINK_B;
              same_class = 1'b1;
            end
            default:    state_nxt = ST_BLINK_B;
          endcase
        end
      endcase
    end
  end

  // A class change or alternation fault restarts confirmation at one sample.
  sat_counter #(.W(4), .LIMIT(4'(CONFIRM_N))) u_confirm (
    .clk (Clock),
    .rst (Reset),
    .clr (sample && !same_class),
    .inc (sample),
    .cnt (conf_cnt)
  );

  sat_counter #(.W(CNT_W), .LIMIT('1)) u_blink (
    .clk (Clock),
    .rst (Reset),
    .clr (clr),
    .inc (blink_inc),
    .cnt (blink_cnt)
  );

  assign mode  = state_mode(state);
  assign valid = (conf_cnt == 4'(CONFIRM_N));

  // s is invisible while steady on, so the last confirmed value is carried forward.
  always_comb begin
    i_now = i_hold;
    s_now = s_hold;
    case (state)
      ST_STEADY_ON:           i_now = 1'b0;
      ST_OFF:                 begin i_now = 1'b1; s_now = 1'b1; end
      ST_BLINK_A, ST_BLINK_B: begin i_now = 1'b1; s_now = 1'b0; end
      default:                ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      i_hold <= 1'b0;
      s_hold <= 1'b0;
    end else if (valid) begin
      i_hold <= i_now;
      s_hold <= s_now;
    end
  end

  assign i_rec = valid ? i_now : i_hold;
  assign s_rec = valid ? s_now : s_hold;

`ifdef LAMP_DEC_STICKY_ERR_EN
  always_ff @(posedge Clock) begin
    if (Reset)      err <= 1'b0;
    else if (fault) err <= 1'b1;
    else if (clr)   err <= 1'b0;
  end
`else
  always_ff @(posedge Clock) begin
    if (Reset) err <= 1'b0;
    else       err <= fault;
  end
`endif

endmodule
